seq_function_unit: RTL and testbench
====================================

SEQ_FUNCTION_UNIT -- requirements
Module: seq_function_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width (>=4).
REQ-002 Parameter SHIFTER_WIDTH, default 5, shift-amount width; SHALL equal clog2(DATA_WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 A, B  input  DATA_WIDTH each  operands.
REQ-008 FunctionSelect  input  4  opcode.
REQ-009 SH  input  SHIFTER_WIDTH  shift amount.
REQ-010 out_valid  output  1  Result/flags valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 Result  output  DATA_WIDTH  result (multiply: low half).
REQ-013 ResultHi  output  DATA_WIDTH  multiply high half; 0 for other ops.
REQ-014 Overflow, CarryOut, Negative, Zero  output  1 each  registered flags.
REQ-015 busy  output  1  multiply in progress.

Function
REQ-016 Request accepted on a cycle with in_valid && in_ready; A, B, FunctionSelect and SH captured then; later input changes are ignored.
REQ-017 States: IDLE, MUL, DONE; rst -> IDLE.
REQ-018 in_ready = (state==IDLE) || (state==DONE && out_ready); a new request may be accepted in the same cycle the current result is consumed.
REQ-019 Single-cycle ops: accept in cycle N -> DONE with out_valid=1 in N+1.
REQ-020 Opcodes: 0000 A; 0001 A+1; 0010 A+B; 0011 A+B+1; 0100 A+~B; 0101 A+~B+1; 0110 A-1; 0111 arithmetic A>>>SH; 1000 A&B; 1001 A|B; 1010 A^B; 1011 ~A; 1100 B; 1101 logical A>>SH; 1110 A<<SH; 1111 unsigned A*B.
REQ-021 Adder ops (0001-0110): CarryOut = bit DATA_WIDTH of the (DATA_WIDTH+1)-bit sum; for 0110, carry computed as A+all-ones (A=0 -> CarryOut=0, else 1).
REQ-022 Overflow for 0001-0110 = signed overflow of (A, second addend) -> Result, second addend being 1, B, B, ~B, ~B, all-ones respectively; Overflow=0 for all logic/shift ops.
REQ-023 1110: CarryOut = last bit shifted out (A[DATA_WIDTH-SH]); SH=0 -> CarryOut=0; all other non-adder ops CarryOut=0.
REQ-024 1111: DONE -> MUL on accept; iterative shift-add, one multiplier bit per cycle, exactly DATA_WIDTH cycles in MUL, then DONE; out_valid first high DATA_WIDTH+1 cycles after accept.
REQ-025 1111 flags: {ResultHi,Result} = full 2*DATA_WIDTH product; Overflow = (ResultHi != 0); CarryOut=0.
REQ-026 Zero = (Result==0) for single-cycle ops, ({ResultHi,Result}==0) for 1111; Negative = Result[DATA_WIDTH-1] for all ops.
REQ-027 busy=1 exactly while state==MUL; in_ready=0 in MUL.
REQ-028 In DONE with out_ready=0, Result, ResultHi, all flags and out_valid SHALL hold stable.
REQ-029 DONE && out_ready && !in_valid -> IDLE, out_valid=0 next cycle.
REQ-030 in_valid while in_ready=0 SHALL be ignored (no capture, no state change).

Reset
REQ-031 rst has priority over all other inputs in the same cycle, including mid-multiply; the in-flight operation is discarded.
REQ-032 Next cycle after rst: state IDLE, out_valid=0, busy=0, in_ready=1, Result=0, ResultHi=0, Overflow=0, CarryOut=0, Zero=1, Negative=0.

Verification
REQ-033 Op 0010, A=0x7FFFFFFF, B=1, out_ready=1 -> next cycle out_valid=1, Result=0x80000000, Overflow=1, Negative=1, CarryOut=0, Zero=0.
REQ-034 Op 0101, A=5, B=5 -> Result=0, Zero=1, CarryOut=1, Overflow=0; op 0110, A=0x80000000 -> Result=0x7FFFFFFF, Overflow=1, CarryOut=1.
REQ-035 Op 1111, A=0xFFFFFFFF, B=2 -> busy 32 cycles, out_valid on cycle 33 after accept, ResultHi=1, Result=0xFFFFFFFE, Overflow=1; in_valid during busy ignored.
REQ-036 Op 1110, A=0x80000001, SH=1 -> Result=0x00000002, CarryOut=1; op 0111, A=0x80000000, SH=4 -> Result=0xF8000000.
REQ-037 Back-to-back: hold out_ready=0 three cycles in DONE -> outputs stable; then out_ready=1 with new in_valid -> new request accepted that cycle, its result valid next cycle.
REQ-038 Assert rst during cycle 10 of a multiply -> next cycle IDLE, busy=0, out_valid=0, Result=0, Zero=1; a following op 0000, A=7 completes normally with Result=7.

Source files
------------

// File: rtl/seq_function_unit.sv
// Sequential function unit: single-cycle ALU/shift ops plus an iterative
// shift-add unsigned multiplier, with valid/ready handshakes on both sides.
module seq_function_unit #(
   parameter int DATA_WIDTH    = 32,
   parameter int SHIFTER_WIDTH = 5   // must equal $clog2(DATA_WIDTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    A,
   input  logic [DATA_WIDTH-1:0]    B,
   input  logic [3:0]               FunctionSelect,
   input  logic [SHIFTER_WIDTH-1:0] SH,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    Result,
   output logic [DATA_WIDTH-1:0]    ResultHi,
   output logic                     Overflow,
   output logic                     CarryOut,
   output logic                     Negative,
   output logic                     Zero,
   output logic                     busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e                    state_q;
   logic [DATA_WIDTH-1:0]     mcand_q;
   logic [2*DATA_WIDTH-1:0]   prod_q;
   logic [SHIFTER_WIDTH-1:0]  cnt_q;
   logic [DATA_WIDTH-1:0]     result_q;
   logic [DATA_WIDTH-1:0]     result_hi_q;
   logic                      overflow_q;
   logic                      carry_q;
   logic                      negative_q;
   logic                      zero_q;

   logic                      accept;
   logic                      mul_last;
   logic [DATA_WIDTH-1:0]     op2;
   logic                      cin;
   logic [DATA_WIDTH:0]       sum;
   logic [DATA_WIDTH:0]       shl;
   logic [DATA_WIDTH-1:0]     alu_res_d;
   logic                      alu_ov_d;
   logic                      alu_co_d;
   logic [DATA_WIDTH:0]       upper_sum;
   logic [2*DATA_WIDTH-1:0]   prod_d;

   assign in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
   assign accept    = in_valid && in_ready;
   assign busy      = (state_q == S_MUL);
   assign out_valid = (state_q == S_DONE);
   assign mul_last  = (cnt_q == SHIFTER_WIDTH'(DATA_WIDTH - 1));

   assign Result    = result_q;
   assign ResultHi  = result_hi_q;
   assign Overflow  = overflow_q;
   assign CarryOut  = carry_q;
   assign Negative  = negative_q;
   assign Zero      = zero_q;

   // Second addend and carry-in shared by all adder opcodes.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      op2 = '0;
      cin = 1'b0;
      unique case (FunctionSelect)
         4'b0001: op2 = DATA_WIDTH'(1);
         4'b0010: op2 = B;
         4'b0011: begin op2 = B;  cin = 1'b1; end
         4'b0100: op2 = ~B;
         4'b0101: begin op2 = ~B; cin = 1'b1; end
         4'b0110: op2 = '1;
         default: ;
      endcase
   end

   assign sum = {1'b0, A} + {1'b0, op2} + {{DATA_WIDTH{1'b0}}, cin};
   assign shl = {1'b0, A} << SH;

   always_comb begin
      alu_res_d = '0;
      alu_ov_d  = 1'b0;
      alu_co_d  = 1'b0;
      unique case (FunctionSelect)
         4'b0000: alu_res_d = A;
         4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110: begin
            alu_res_d = sum[DATA_WIDTH-1:0];
            alu_co_d  = sum[DATA_WIDTH];
            alu_ov_d  = (A[DATA_WIDTH-1] == op2[DATA_WIDTH-1]) &&
                        (sum[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
         end
         4'b0111: alu_res_d = $signed(A) >>> SH;
         4'b1000: alu_res_d = A & B;
         4'b1001: alu_res_d = A | B;
         4'b1010: alu_res_d = A ^ B;
         4'b1011: alu_res_d = ~A;
         4'b1100: alu_res_d = B;
         4'b1101: alu_res_d = A >> SH;
         4'b1110: begin
            alu_res_d = shl[DATA_WIDTH-1:0];
            alu_co_d  = shl[DATA_WIDTH];  // last bit shifted out, 0 when SH==0
         end
         default: ;  // 1111 is handled by the multiplier
      endcase
   end

   // One shift-add step: low half of prod_q holds the remaining multiplier bits.
   assign upper_sum = {1'b0, prod_q[2*DATA_WIDTH-1:DATA_WIDTH]} +
                      (prod_q[0] ? {1'b0, mcand_q} : '0);
   assign prod_d    = {upper_sum, prod_q[DATA_WIDTH-1:1]};

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mcand_q     <= '0;
         prod_q      <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         result_hi_q <= '0;
         overflow_q  <= 1'b0;
         carry_q     <= 1'b0;
         negative_q  <= 1'b0;
         zero_q      <= 1'b1;
      end else begin
         unique case (state_q)
            S_MUL: begin
               prod_q <= prod_d;
               cnt_q  <= cnt_q + SHIFTER_WIDTH'(1);
               if (mul_last) begin
                  state_q     <= S_DONE;
                  result_q    <= prod_d[DATA_WIDTH-1:0];
                  result_hi_q <= prod_d[2*DATA_WIDTH-1:DATA_WIDTH];
                  overflow_q  <= |prod_d[2*DATA_WIDTH-1:DATA_WIDTH];
                  carry_q     <= 1'b0;
                  negative_q  <= prod_d[DATA_WIDTH-1];
                  zero_q      <= (prod_d == '0);
               end
            end
            default: begin
               if (accept) begin
                  if (FunctionSelect == 4'b1111) begin
                     state_q <= S_MUL;
                     mcand_q <= A;
                     prod_q  <= {{DATA_WIDTH{1'b0}}, B};
                     cnt_q   <= '0;
                  end else begin
                     state_q     <= S_DONE;
                     result_q    <= alu_res_d;
                     result_hi_q <= '0;
                     overflow_q  <= alu_ov_d;
                     carry_q     <= alu_co_d;
                     negative_q  <= alu_res_d[DATA_WIDTH-1];
                     zero_q      <= (alu_res_d == '0);
                  end
               end else if (state_q == S_DONE && out_ready) begin
                  state_q <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_function_unit.sv
// Self-checking bench for seq_function_unit: directed corner cases plus
// randomized operations compared against an arithmetic reference model.
module tb_seq_function_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  FunctionSelect;
   logic [4:0]  SH;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Result;
   logic [31:0] ResultHi;
   logic        Overflow;
   logic        CarryOut;
   logic        Negative;
   logic        Zero;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] res;
      logic [31:0] hi;
      logic        ov;
      logic        co;
      logic        neg;
      logic        zero;
   } exp_t;

   seq_function_unit #(.DATA_WIDTH(32), .SHIFTER_WIDTH(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .A              (A),
      .B              (B),
      .FunctionSelect (FunctionSelect),
      .SH             (SH),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .Result         (Result),
      .ResultHi       (ResultHi),
      .Overflow       (Overflow),
      .CarryOut       (CarryOut),
      .Negative       (Negative),
      .Zero           (Zero),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain wide arithmetic, no knowledge of the datapath.
   function automatic exp_t model(input logic [3:0] fs, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] sh);
      exp_t              e;
      longint unsigned   ua;
      longint unsigned   full;
      longint            s;
      logic [31:0]       op2;
      logic              cin;
      logic              is_add;
      ua     = {32'd0, a};
      op2    = 32'd0;
      cin    = 1'b0;
      is_add = 1'b0;
      e.res  = 32'd0;
      e.hi   = 32'd0;
      e.ov   = 1'b0;
      e.co   = 1'b0;
      case (fs)
         4'h0: e.res = a;
         4'h1: begin op2 = 32'd1;        is_add = 1'b1; end
         4'h2: begin op2 = b;            is_add = 1'b1; end
         4'h3: begin op2 = b; cin = 1'b1; is_add = 1'b1; end
         4'h4: begin op2 = ~b;           is_add = 1'b1; end
         4'h5: begin op2 = ~b; cin = 1'b1; is_add = 1'b1; end
         4'h6: begin op2 = 32'hFFFF_FFFF; is_add = 1'b1; end
         4'h7: e.res = $signed(a) >>> sh;
         4'h8: e.res = a & b;
         4'h9: e.res = a | b;
         4'hA: e.res = a ^ b;
         4'hB: e.res = ~a;
         4'hC: e.res = b;
         4'hD: e.res = a >> sh;
         4'hE: begin
            full  = ua << sh;
            e.res = full[31:0];
            e.co  = full[32];
         end
         default: begin
            full  = ua * {32'd0, b};
            e.res = full[31:0];
            e.hi  = full[63:32];
            e.ov  = (e.hi != 32'd0);
         end
      endcase
      if (is_add) begin
         full  = ua + {32'd0, op2} + {63'd0, cin};
         e.res = full[31:0];
         e.co  = full[32];
         s     = longint'($signed(a)) + longint'($signed(op2)) + longint'(cin);
         e.ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      e.neg  = e.res[31];
      e.zero = (fs == 4'hF) ? ({e.hi, e.res} == 64'd0) : (e.res == 32'd0);
      return e;
   endfunction

   task automatic check_outputs(input string tag, input exp_t e);
      check({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
      check({tag, ".res"},   {32'd0, Result},    {32'd0, e.res});
      check({tag, ".hi"},    {32'd0, ResultHi},  {32'd0, e.hi});
      check({tag, ".flags"}, {60'd0, Overflow, CarryOut, Negative, Zero},
                             {60'd0, e.ov, e.co, e.neg, e.zero});
   endtask

   task automatic drive_req(input logic [3:0] fs, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] sh);
      in_valid       = 1'b1;
      FunctionSelect = fs;
      A              = a;
      B              = b;
      SH             = sh;
   endtask

   task automatic scramble_inputs();
      A              = $urandom;
      B              = $urandom;
      FunctionSelect = 4'($urandom);
      SH             = 5'($urandom);
   endtask

   // Issue one op from IDLE, wait for its result, hold it for `stall` cycles
   // while junk requests are offered, then consume it.
   task automatic run_op(input string tag, input logic [3:0] fs, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input int stall);
      exp_t e;
      int   lat;
      e = model(fs, a, b, sh);
      out_ready = 1'b0;
      check({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
      drive_req(fs, a, b, sh);
      step();
      lat = 1;
      scramble_inputs();
      in_valid = (fs == 4'hF);
      while (!out_valid && lat < 100) begin
         check({tag, ".busy"}, {62'd0, busy, in_ready}, 64'd2);
         step();
         lat++;
      end
      check({tag, ".latency"}, 64'(lat), (fs == 4'hF) ? 64'd33 : 64'd1);
      check_outputs(tag, e);
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'($urandom);
         scramble_inputs();
         step();
      end
      if (stall > 0) check_outputs({tag, ".hold"}, e);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, ".drain"}, {62'd0, out_valid, busy}, 64'd0);
   endtask

   initial begin
      exp_t e0;
      exp_t e1;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A = '0; B = '0; FunctionSelect = '0; SH = '0;
      step();
      step();
      rst = 1'b0;
      check("reset.ctrl", {61'd0, out_valid, busy, in_ready}, 64'd1);
      check("reset.res", {Result, ResultHi}, 64'd0);
      check("reset.flags", {60'd0, Overflow, CarryOut, Negative, Zero}, 64'd1);

      run_op("add_ovf",  4'h2, 32'h7FFF_FFFF, 32'd1, 5'd0, 0);
      run_op("sub_zero", 4'h5, 32'd5, 32'd5, 5'd0, 1);
      run_op("dec_min",  4'h6, 32'h8000_0000, 32'd0, 5'd0, 0);
      run_op("dec_zero", 4'h6, 32'd0, 32'd0, 5'd0, 0);
      run_op("mul_ff2",  4'hF, 32'hFFFF_FFFF, 32'd2, 5'd0, 2);
      run_op("mul_zero", 4'hF, 32'd0, 32'hDEAD_BEEF, 5'd0, 0);
      run_op("shl_c",    4'hE, 32'h8000_0001, 32'd0, 5'd1, 0);
      run_op("shl_0",    4'hE, 32'hFFFF_FFFF, 32'd0, 5'd0, 0);
      run_op("sra_4",    4'h7, 32'h8000_0000, 32'd0, 5'd4, 0);
      run_op("srl_31",   4'hD, 32'h8000_0000, 32'd0, 5'd31, 0);

      // Back-to-back: result held three cycles, then consumed with a new request.
      e0 = model(4'h2, 32'h1234_5678, 32'h0F0F_0F0F, 5'd0);
      e1 = model(4'h4, 32'h0000_0010, 32'h0000_0003, 5'd0);
      drive_req(4'h2, 32'h1234_5678, 32'h0F0F_0F0F, 5'd0);
      step();
      in_valid = 1'b0;
      scramble_inputs();
      for (int i = 0; i < 3; i++) begin
         check_outputs("b2b.hold", e0);
         step();
      end
      check_outputs("b2b.hold", e0);
      drive_req(4'h4, 32'h0000_0010, 32'h0000_0003, 5'd0);
      out_ready = 1'b1;
      #1;
      check("b2b.in_ready", {63'd0, in_ready}, 64'd1);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check_outputs("b2b.second", e1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("b2b.drain", {63'd0, out_valid}, 64'd0);

      // Reset during the tenth multiply cycle discards the operation.
      drive_req(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) step();
      check("rstmul.busy", {63'd0, busy}, 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rstmul.ctrl", {61'd0, out_valid, busy, in_ready}, 64'd1);
      check("rstmul.res", {Result, ResultHi}, 64'd0);
      check("rstmul.flags", {60'd0, Overflow, CarryOut, Negative, Zero}, 64'd1);
      run_op("after_rst", 4'h0, 32'd7, 32'd0, 5'd0, 0);

      // Randomized operations with occasional corner operands.
      for (int n = 0; n < 150; n++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra = 32'h8000_0000;
            1: rb = 32'hFFFF_FFFF;
            2: ra = 32'd0;
            default: ;
         endcase
         run_op("rand", 4'($urandom), ra, rb, 5'($urandom), int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
